// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encodings, speed codes, limits.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPEED   = 3'd1,
    S_SPDWAIT = 3'd2,
    S_SEND    = 3'd3,
    S_HOLD    = 3'd4
  } arb_state_t;

  localparam logic SPEED_DEFAULT = 1'b0;
  localparam logic SPEED_ALT     = 1'b1;

  localparam int MAX_REQ = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The winner is the first asserted
// request strictly after i_ptr, wrapping around, so the last owner goes last.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Rotate the request vector so bit 0 is the slot right after the pointer.
  logic [N-1:0] w_rot;
  assign w_rot = N'({i_req, i_req} >> (int'(i_ptr) + 1));

  // Lowest set bit of the rotated vector wins; map it back to a lane index.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + 1 + k) % N);
      end
    end
  end

  assign o_onehot = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter.
// Switches the UART baud speed per packet before the first byte goes out.
// Optional stall timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  input  logic [NUM_REQ-1:0]     i_req_speed,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_send,
  input  logic                   i_tx_busy,
  output logic                   o_tx_req_speed,
  input  logic                   i_tx_cur_speed,
  output logic                   o_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][7:0] w_lanes;
  logic [NUM_REQ-1:0]      w_win_oh;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_any;

  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_gidx;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_ready;
  logic                    r_send;
  logic [7:0]              r_data;
  logic                    r_req_speed;
  logic                    r_last;
  logic                    r_hold1;
`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]             r_cnt;
  logic                    r_timeout;
`endif

  assign w_lanes = i_req_data;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // Arbitration FSM: grant, speed switch, byte send, post-send hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_gidx      <= '0;
      r_grant     <= '0;
      r_ready     <= '0;
      r_send      <= 1'b0;
      r_data      <= '0;
      r_req_speed <= SPEED_DEFAULT;
      r_last      <= 1'b0;
      r_hold1     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_ready <= '0;
      r_send  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win_oh;
            r_gidx  <= w_win_idx;
            r_state <= S_SPEED;
          end
        end
        S_SPEED: begin
          // Only retune between frames so a byte in flight keeps its baud.
          if (i_req_speed[r_gidx] == r_req_speed) begin
            r_state <= S_SEND;
          end else if (!i_tx_busy) begin
            r_req_speed <= i_req_speed[r_gidx];
            r_state     <= S_SPDWAIT;
          end
        end
        S_SPDWAIT: begin
          if (i_tx_cur_speed == r_req_speed) r_state <= S_SEND;
        end
        S_SEND: begin
          if (i_req_valid[r_gidx] && !i_tx_busy) begin
            r_data          <= w_lanes[r_gidx];
            r_send          <= 1'b1;
            r_ready[r_gidx] <= 1'b1;
            r_last          <= i_req_last[r_gidx];
            r_hold1         <= 1'b1;
            r_state         <= S_HOLD;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt           <= '0;
          end else if (!i_req_valid[r_gidx]) begin
            if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
              r_timeout <= 1'b1;
              r_ptr     <= r_gidx;
              r_grant   <= '0;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
`endif
          end
        end
        S_HOLD: begin
          // First cycle is blind: the UART only raises busy a cycle after the strobe.
          if (r_hold1) begin
            r_hold1 <= 1'b0;
          end else if (!i_tx_busy) begin
            if (r_last) begin
              r_ptr   <= r_gidx;
              r_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready    = r_ready;
  assign o_grant        = r_grant;
  assign o_tx_data      = r_data;
  assign o_tx_send      = r_send;
  assign o_tx_req_speed = r_req_speed;
`ifdef UART_ARB_TIMEOUT_EN
  assign o_timeout      = r_timeout;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule
